audio_out_sequencer: RTL and testbench
======================================

AUDIO_OUT_SEQUENCER -- requirements
Module: audio_out_sequencer

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, width of each audio FIFO data word.
REQ-002 SHALL have parameter OUT_WIDTH, default 16, width of each emitted audio sample.
REQ-003 SHALL have parameter SAMPLE_DIV, default 16, number of clock cycles per output sample period; legal range 4..65535.
REQ-004 SHALL have port clock, input, 1, the only clock for all state.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1, which runs the sequencer when high.
REQ-007 SHALL have ports left_audio_empty and right_audio_empty, input, 1 each, which indicate that the corresponding audio FIFO is empty.
REQ-008 SHALL have ports left_audio_dout and right_audio_dout, input, DATA_SIZE each, signed FIFO heads in first-word-fall-through form (valid while the matching empty is low).
REQ-009 SHALL have ports left_audio_rd_en and right_audio_rd_en, output, 1 each, FIFO pop strobes.
REQ-010 SHALL have port out_valid, output, 1, a one-cycle strobe marking a new sample pair.
REQ-011 SHALL have ports out_left and out_right, output, OUT_WIDTH each, signed samples.
REQ-012 SHALL have port underrun, output, 1, a one-cycle strobe marking a period with no sample available.
REQ-013 SHALL have port underrun_count, output, 16, count of underruns.

Function
REQ-014 SHALL contain a period counter 0..SAMPLE_DIV-1 that increments each cycle while enable=1, wraps to 0 after SAMPLE_DIV-1, and is held at 0 while enable=0.
REQ-015 SHALL define tick as enable=1 AND counter=SAMPLE_DIV-1, so the first tick occurs on the SAMPLE_DIV-th cycle after enable rises.
REQ-016 SHALL implement two states: EMPTY (pair buffer holds no pair) and LOADED (pair buffer holds one pair).
REQ-017 SHALL drive left_audio_rd_en = right_audio_rd_en = (state=EMPTY AND enable AND !left_audio_empty AND !right_audio_empty), combinationally, with the two strobes always identical.
REQ-018 SHALL, on any clock edge where rd_en=1, capture both FIFO heads into the pair buffer and transition EMPTY->LOADED.
REQ-019 SHALL NOT pop either FIFO when only one FIFO is non-empty.
REQ-020 SHALL NOT assert rd_en in LOADED.
REQ-021 SHALL, on a tick in LOADED, register the saturated buffered pair onto out_left/out_right, pulse out_valid for exactly one cycle (the cycle after the tick edge), and transition LOADED->EMPTY.
REQ-022 SHALL, on a tick in EMPTY, drive out_left=out_right=0, pulse both out_valid and underrun for one cycle, and increment underrun_count.
REQ-023 SHALL, when tick and rd_en coincide in EMPTY, apply both actions: the tick is an underrun and the captured pair moves the state to LOADED for the next period.
REQ-024 SHALL saturate DATA_SIZE to OUT_WIDTH signed: values above 2^(OUT_WIDTH-1)-1 map to that maximum, values below -2^(OUT_WIDTH-1) map to that minimum, and all other values keep their low OUT_WIDTH bits.
REQ-025 SHALL hold out_left/out_right at their last values between out_valid strobes.
REQ-026 SHALL saturate underrun_count at 0xFFFF; the count clears only on reset.
REQ-027 SHALL, when enable falls mid-period, retain state and buffer contents, zero the counter, and emit no rd_en, out_valid or underrun until re-enabled.

Reset
REQ-028 SHALL, while reset=0, asynchronously force state=EMPTY, counter=0, buffer=0, out_left=out_right=0, out_valid=0, underrun=0, underrun_count=0.
REQ-029 SHALL keep rd_en strobes at 0 while reset=0 regardless of FIFO flags.
REQ-030 SHALL leave popped data that is discarded by a mid-operation reset unrecovered; it is lost by design.

Verification (SAMPLE_DIV=16, OUT_WIDTH=16, DATA_SIZE=32)
REQ-031 Bench SHALL check: reset asserted with both FIFOs non-empty -> all outputs 0, no rd_en.
REQ-032 Bench SHALL check: left=0x00000123, right=0xFFFFFF00, enable=1 -> one rd_en pulse on both FIFOs on the first enabled cycle, out_valid in cycle 16 with out_left=0x0123 and out_right=0xFF00.
REQ-033 Bench SHALL check: left=0x00012345, right=0xFFFE0000 -> out_left=0x7FFF, out_right=0x8000.
REQ-034 Bench SHALL check: only left FIFO non-empty for 2 periods -> no rd_en, two out_valid+underrun pulses with zero data, underrun_count=2.
REQ-035 Bench SHALL check: LOADED, enable dropped at counter=7 for 5 cycles -> no strobes, counter=0; after re-enable, out_valid 16 cycles later with the original pair and no extra pop.
REQ-036 Bench SHALL check: 100 pairs streamed with FIFOs never empty -> 100 out_valid pulses exactly 16 cycles apart, underrun_count=0, and pair order preserved.

Source files
------------

// File: rtl/audio_out_sequencer.sv
// Paces stereo samples from two FWFT audio FIFOs onto a fixed-rate output,
// saturating each word and flagging periods where no full pair was available.
module audio_out_sequencer #(
    parameter int DATA_SIZE  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int SAMPLE_DIV = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 left_audio_empty,
    input  logic                 right_audio_empty,
    input  logic [DATA_SIZE-1:0] left_audio_dout,
    input  logic [DATA_SIZE-1:0] right_audio_dout,
    output logic                 left_audio_rd_en,
    output logic                 right_audio_rd_en,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_left,
    output logic [OUT_WIDTH-1:0] out_right,
    output logic                 underrun,
    output logic [15:0]          underrun_count
);

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_LOADED = 1'b1
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(SAMPLE_DIV - 1);

    state_t                 state_q;
    logic [15:0]            cnt_q;
    logic [15:0]            cnt_d;
    logic [DATA_SIZE-1:0]   buf_left_q;
    logic [DATA_SIZE-1:0]   buf_right_q;
    logic [OUT_WIDTH-1:0]   out_left_q;
    logic [OUT_WIDTH-1:0]   out_right_q;
    logic                   out_valid_q;
    logic                   underrun_q;
    logic [15:0]            underrun_count_q;
    logic                   tick_s;
    logic                   rd_en_s;

    // The word fits when every bit above the output sign bit copies it.
    function automatic logic [OUT_WIDTH-1:0] saturate(input logic [DATA_SIZE-1:0] v);
        logic [DATA_SIZE-OUT_WIDTH:0] top;
        top = v[DATA_SIZE-1:OUT_WIDTH-1];
        if ((top == {(DATA_SIZE-OUT_WIDTH+1){1'b0}}) || (top == {(DATA_SIZE-OUT_WIDTH+1){1'b1}})) begin
            saturate = v[OUT_WIDTH-1:0];
        end else if (v[DATA_SIZE-1]) begin
            saturate = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            saturate = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    endfunction

    // Period tick, pop strobe and next counter value.
    always_comb begin
        tick_s  = enable && (cnt_q == CNT_LAST);
        rd_en_s = reset && enable && (state_q == ST_EMPTY)
                  && !left_audio_empty && !right_audio_empty;
        if (!enable) begin
            cnt_d = 16'd0;
        end else if (tick_s) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Sample-period counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Pair-buffer FSM with registered sample, strobe and underrun outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_EMPTY;
            buf_left_q       <= {DATA_SIZE{1'b0}};
            buf_right_q      <= {DATA_SIZE{1'b0}};
            out_left_q       <= {OUT_WIDTH{1'b0}};
            out_right_q      <= {OUT_WIDTH{1'b0}};
            out_valid_q      <= 1'b0;
            underrun_q       <= 1'b0;
            underrun_count_q <= 16'd0;
        end else begin
            out_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            case (state_q)
                ST_EMPTY: begin
                    if (tick_s) begin
                        out_left_q  <= {OUT_WIDTH{1'b0}};
                        out_right_q <= {OUT_WIDTH{1'b0}};
                        out_valid_q <= 1'b1;
                        underrun_q  <= 1'b1;
                        if (underrun_count_q != 16'hFFFF) begin
                            underrun_count_q <= underrun_count_q + 16'd1;
                        end
                    end
                    // A pair captured on an underrun tick plays in the next period.
                    if (rd_en_s) begin
                        buf_left_q  <= left_audio_dout;
                        buf_right_q <= right_audio_dout;
                        state_q     <= ST_LOADED;
                    end
                end
                ST_LOADED: begin
                    if (tick_s) begin
                        out_left_q  <= saturate(buf_left_q);
                        out_right_q <= saturate(buf_right_q);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_EMPTY;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

    assign left_audio_rd_en  = rd_en_s;
    assign right_audio_rd_en = rd_en_s;
    assign out_valid         = out_valid_q;
    assign out_left          = out_left_q;
    assign out_right         = out_right_q;
    assign underrun          = underrun_q;
    assign underrun_count    = underrun_count_q;

endmodule

// File: tb/tb_audio_out_sequencer.sv
// Self-checking bench: emulated FWFT FIFOs, a period/queue reference model,
// a saturation vector table and hand-written multi-cycle sequences.
module tb_audio_out_sequencer;

    localparam int SD = 16;

    typedef struct packed {
        logic [31:0] l;
        logic [31:0] r;
    } pair_t;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
        logic [15:0] el;
        logic [15:0] er;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        le, re;
    logic [31:0] ld, rd;
    logic        lre, rre, ov, ur;
    logic [15:0] ol, orr, uc;

    logic [31:0] lq[$];
    logic [31:0] rq[$];
    pair_t       m_buf[$];
    pair_t       exp_stream[$];
    int          m_phase;
    logic [15:0] m_ol, m_or;
    bit          m_valid, m_under;
    int          m_ucount;
    int          tests, fails, cyc, rd_pulses;

    audio_out_sequencer #(.DATA_SIZE(32), .OUT_WIDTH(16), .SAMPLE_DIV(SD)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .left_audio_empty(le), .right_audio_empty(re),
        .left_audio_dout(ld), .right_audio_dout(rd),
        .left_audio_rd_en(lre), .right_audio_rd_en(rre),
        .out_valid(ov), .out_left(ol), .out_right(orr),
        .underrun(ur), .underrun_count(uc)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] sat(input logic [31:0] v);
        longint s;
        s = longint'($signed(v));
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] b;
        b = $urandom;
        case ($urandom_range(0, 2))
            0: return {{16{b[15]}}, b[15:0]};
            1: return b;
            default: return {{15{b[16]}}, b[16:0]};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive_fifo();
        le = (lq.size() == 0);
        re = (rq.size() == 0);
        ld = le ? 32'hDEAD_BEEF : lq[0];
        rd = re ? 32'hBEEF_DEAD : rq[0];
    endtask

    task automatic push_pair(input logic [31:0] l, input logic [31:0] r);
        lq.push_back(l);
        rq.push_back(r);
    endtask

    // One clock: check pop strobes before the edge, advance the model, check outputs after it.
    task automatic step();
        bit    exp_rd, tick, l_pop, r_pop;
        pair_t p;
        drive_fifo();
        #3;
        exp_rd = reset && enable && (m_buf.size() == 0) && (lq.size() > 0) && (rq.size() > 0);
        check("left_rd_en", 32'(lre), 32'(exp_rd));
        check("right_rd_en", 32'(rre), 32'(exp_rd));
        l_pop = lre;
        r_pop = rre;
        @(posedge clock);
        cyc++;
        if (l_pop) rd_pulses++;
        if (!reset) begin
            m_phase = 0;
            m_buf.delete();
            m_ol = 16'h0; m_or = 16'h0;
            m_valid = 0; m_under = 0; m_ucount = 0;
        end else begin
            tick = enable && (m_phase == SD - 1);
            m_valid = 0;
            m_under = 0;
            if (tick) begin
                if (m_buf.size() > 0) begin
                    p = m_buf.pop_front();
                    m_ol = sat(p.l);
                    m_or = sat(p.r);
                end else begin
                    m_ol = 16'h0; m_or = 16'h0;
                    m_under = 1;
                    if (m_ucount < 65535) m_ucount++;
                end
                m_valid = 1;
            end
            if (exp_rd) begin
                p.l = lq[0];
                p.r = rq[0];
                m_buf.push_back(p);
            end
            m_phase = enable ? (m_phase + 1) % SD : 0;
        end
        if (l_pop && lq.size() > 0) void'(lq.pop_front());
        if (r_pop && rq.size() > 0) void'(rq.pop_front());
        #1;
        check("out_valid", 32'(ov), 32'(m_valid));
        check("underrun", 32'(ur), 32'(m_under));
        check("out_left", 32'(ol), 32'(m_ol));
        check("out_right", 32'(orr), 32'(m_or));
        check("underrun_count", 32'(uc), 32'(m_ucount));
    endtask

    task automatic do_reset();
        enable = 1'b0;
        reset  = 1'b0;
        step();
        reset = 1'b1;
        rd_pulses = 0;
    endtask

    initial begin
        vec_t vecs[6];
        int   last;
        vecs[0] = '{32'h0000_0123, 32'hFFFF_FF00, 16'h0123, 16'hFF00};
        vecs[1] = '{32'h0001_2345, 32'hFFFE_0000, 16'h7FFF, 16'h8000};
        vecs[2] = '{32'h0000_7FFF, 32'hFFFF_8000, 16'h7FFF, 16'h8000};
        vecs[3] = '{32'h0000_8000, 32'hFFFF_7FFF, 16'h7FFF, 16'h8000};
        vecs[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 16'h7FFF, 16'h8000};
        vecs[5] = '{32'h0000_0000, 32'hFFFF_FFFF, 16'h0000, 16'hFFFF};
        tests = 0; fails = 0; cyc = 0; rd_pulses = 0;
        m_phase = 0; m_ol = 16'h0; m_or = 16'h0; m_valid = 0; m_under = 0; m_ucount = 0;

        // Reset held with both FIFOs non-empty and enable high.
        reset = 1'b0;
        enable = 1'b1;
        push_pair(32'h1111_1111, 32'h2222_2222);
        for (int i = 0; i < 3; i++) step();
        check("reset_no_pop", 32'(rd_pulses), 32'd0);
        check("reset_out_left", 32'(ol), 32'h0);
        lq.delete(); rq.delete();
        do_reset();

        // Saturation table: one pair per period, output on the 16th enabled edge.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            push_pair(vecs[v].l, vecs[v].r);
            enable = 1'b1;
            step();
            check("vec_first_cycle_pop", 32'(rd_pulses), 32'd1);
            for (int i = 1; i < SD; i++) step();
            check("vec_valid", 32'(ov), 32'd1);
            check("vec_left", 32'(ol), 32'(vecs[v].el));
            check("vec_right", 32'(orr), 32'(vecs[v].er));
            step();
            check("vec_hold_left", 32'(ol), 32'(vecs[v].el));
        end

        // Only the left FIFO has data for two periods.
        do_reset();
        for (int i = 0; i < 3; i++) lq.push_back(32'h0000_0042);
        enable = 1'b1;
        for (int i = 0; i < 2 * SD; i++) step();
        check("left_only_no_pop", 32'(rd_pulses), 32'd0);
        check("left_only_ucount", 32'(uc), 32'd2);
        lq.delete();

        // Tick and pop coincide in EMPTY.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < SD - 1; i++) step();
        push_pair(32'h0000_0777, 32'hFFFF_F888);
        step();
        check("coincide_underrun", 32'(ur), 32'd1);
        for (int i = 0; i < SD; i++) step();
        check("coincide_valid", 32'(ov), 32'd1);
        check("coincide_left", 32'(ol), 32'h0777);
        check("coincide_ucount", 32'(uc), 32'd1);

        // Enable dropped mid-period while LOADED.
        do_reset();
        push_pair(32'h0000_0ABC, 32'hFFFF_FDEF);
        enable = 1'b1;
        step();
        push_pair(32'h0000_0001, 32'h0000_0002);
        for (int i = 1; i < 7; i++) step();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) step();
        enable = 1'b1;
        for (int i = 0; i < SD; i++) step();
        check("resume_valid", 32'(ov), 32'd1);
        check("resume_left", 32'(ol), 32'h0ABC);
        check("resume_right", 32'(orr), 32'hFDEF);
        check("resume_single_pop", 32'(rd_pulses), 32'd1);
        lq.delete(); rq.delete();

        // 100 pairs streamed with FIFOs kept non-empty.
        begin
            int pushed, pulses;
            pair_t p;
            do_reset();
            pushed = 0; pulses = 0; last = -1;
            enable = 1'b1;
            for (int i = 0; i < 100 * SD; i++) begin
                while (pushed < 100 && lq.size() < 2) begin
                    p.l = rand_word(); p.r = rand_word();
                    push_pair(p.l, p.r);
                    exp_stream.push_back(p);
                    pushed++;
                end
                step();
                if (ov) begin
                    pulses++;
                    if (last >= 0) check("stream_gap", 32'(cyc - last), 32'(SD));
                    last = cyc;
                    if (exp_stream.size() > 0) begin
                        p = exp_stream.pop_front();
                        check("stream_left", 32'(ol), 32'(sat(p.l)));
                        check("stream_right", 32'(orr), 32'(sat(p.r)));
                    end
                end
            end
            check("stream_pulses", 32'(pulses), 32'd100);
            check("stream_ucount", 32'(uc), 32'd0);
        end

        // Randomized traffic, enable toggling and occasional reset.
        lq.delete(); rq.delete();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            reset  = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 19) == 0 && lq.size() < 4) lq.push_back(rand_word());
            if ($urandom_range(0, 19) == 0 && rq.size() < 4) rq.push_back(rand_word());
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
